// File: rtl/mux2_arbiter.sv
// mux2_arbiter: two-requester round-robin arbiter that steers one of two
// data inputs onto a shared output.
//
// Handshake: a requester raises reqx and keeps it high for as long as it wants
// the mux. The matching gntx rises one cycle after the request is sampled in
// IDLE. gntx stays high while reqx=1 and lastx=0. Sampling lastx=1 or reqx=0
// releases the grant at the next edge. lastx is ignored while gntx is low.
//
// Optional feature (macro MUX2_ARB_TIMEOUT_EN): a hold counter limits a grant
// to HOLD_MAX cycles, but only while the other requester is waiting. A forced
// hand-over pulses timeout for one cycle. Without the macro there is no
// counter and timeout is tied low.
//
// Parameters:
//   WIDTH     data width of in1/in2/out
//   HOLD_MAX  maximum grant length with the timeout feature (2..255)
// Ports:
//   clk            rising-edge clock
//   rst_n          synchronous active-low reset
//   req1/req2      requests
//   last1/last2    final-cycle markers for the granted requester
//   in1/in2        requester data
//   gnt1/gnt2      registered grants, mutually exclusive
//   s              registered select (1 only while requester 2 holds a grant)
//   out            s ? in2 : in1, combinational
//   out_valid      gnt1 | gnt2
//   timeout        one-cycle pulse on a forced hand-over
//   dbg_state      current FSM state (0 IDLE, 1 GNT1, 2 GNT2) for observation
module mux2_arbiter #(
  parameter int WIDTH    = 8,
  parameter int HOLD_MAX = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req1,
  input  logic             req2,
  input  logic             last1,
  input  logic             last2,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             gnt1,
  output logic             gnt2,
  output logic             s,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             timeout,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT1 = 2'd1,
    GNT2 = 2'd2
  } state_t;

  state_t state, state_nxt;
  // prio=0 favours requester 1 on a tie, prio=1 favours requester 2.
  logic   prio, prio_nxt;

`ifdef MUX2_ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);
  logic [7:0] cnt, cnt_nxt;
  logic       to_nxt;
  logic       limit1, limit2;

  // The limit only matters when the other side is actually waiting.
  assign limit1 = (cnt == HOLD_LIM) && req2;
  assign limit2 = (cnt == HOLD_LIM) && req1;
`else
  logic limit1, limit2;
  assign limit1 = 1'b0;
  assign limit2 = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    prio_nxt  = prio;
    unique case (state)
      IDLE: begin
        if (req1 && (!req2 || !prio)) begin
          state_nxt = GNT1;
          prio_nxt  = 1'b1;
        end else if (req2) begin
          state_nxt = GNT2;
          prio_nxt  = 1'b0;
        end
      end
      GNT1: begin
        // Release hands straight over to a waiting requester 2 (no bubble).
        if (last1 || !req1) begin
          if (req2) begin
            state_nxt = GNT2;
            prio_nxt  = 1'b0;
          end else begin
            state_nxt = IDLE;
          end
        end else if (limit1) begin
          state_nxt = GNT2;
          prio_nxt  = 1'b0;
        end
      end
      GNT2: begin
        if (last2 || !req2) begin
          if (req1) begin
            state_nxt = GNT1;
            prio_nxt  = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end else if (limit2) begin
          state_nxt = GNT1;
          prio_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef MUX2_ARB_TIMEOUT_EN
  always_comb begin
    cnt_nxt = cnt;
    to_nxt  = 1'b0;
    if (state_nxt == IDLE) begin
      cnt_nxt = 8'd0;
    end else if (state_nxt != state) begin
      // Any grant entry, including a direct hand-over, restarts the count at 1.
      cnt_nxt = 8'd1;
      to_nxt  = (state == GNT1 && limit1 && !(last1 || !req1)) ||
                (state == GNT2 && limit2 && !(last2 || !req2));
    end else if (cnt != HOLD_LIM) begin
      cnt_nxt = cnt + 8'd1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      prio  <= 1'b0;
      gnt1  <= 1'b0;
      gnt2  <= 1'b0;
      s     <= 1'b0;
`ifdef MUX2_ARB_TIMEOUT_EN
      cnt     <= 8'd0;
      timeout <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      prio  <= prio_nxt;
      gnt1  <= (state_nxt == GNT1);
      gnt2  <= (state_nxt == GNT2);
      s     <= (state_nxt == GNT2);
`ifdef MUX2_ARB_TIMEOUT_EN
      cnt     <= cnt_nxt;
      timeout <= to_nxt;
`endif
    end
  end

`ifndef MUX2_ARB_TIMEOUT_EN
  assign timeout = 1'b0;
`endif

  assign out       = s ? in2 : in1;
  assign out_valid = gnt1 | gnt2;
  assign dbg_state = state;

endmodule

// File: tb/tb_mux2_arbiter.sv
// Self-checking bench for mux2_arbiter: directed scenarios followed by a
// randomized run, all compared against a reference model of grant ownership.
module tb_mux2_arbiter;

  localparam int W  = 8;
  localparam int HM = 4;
`ifdef MUX2_ARB_TIMEOUT_EN
  localparam bit TEN = 1'b1;
`else
  localparam bit TEN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req1 = 1'b0, req2 = 1'b0, last1 = 1'b0, last2 = 1'b0;
  logic [W-1:0] in1 = '0, in2 = '0;
  logic         gnt1, gnt2, s, out_valid, timeout;
  logic [W-1:0] out;
  logic [1:0]   dbg_state;

  mux2_arbiter #(.WIDTH(W), .HOLD_MAX(HM)) dut (
    .clk(clk), .rst_n(rst_n), .req1(req1), .req2(req2),
    .last1(last1), .last2(last2), .in1(in1), .in2(in2),
    .gnt1(gnt1), .gnt2(gnt2), .s(s), .out(out),
    .out_valid(out_valid), .timeout(timeout), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Reference model: who owns the mux (0 none, 1, 2), tie-break favourite,
  // saturating hold count, raw grant length and the forced-release pulse.
  int m_owner = 0;
  int m_fav   = 1;
  int m_cnt   = 0;
  int m_len   = 0;
  bit m_to    = 1'b0;

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic give(input int who);
    m_owner = who;
    m_fav   = 3 - who;
    m_cnt   = 1;
    m_len   = 1;
  endtask

  task automatic model_step();
    bit my_req, my_last, other_req;
    m_to = 1'b0;
    if (!rst_n) begin
      m_owner = 0; m_fav = 1; m_cnt = 0; m_len = 0;
      return;
    end
    if (m_owner == 0) begin
      if (req1 && req2) give(m_fav);
      else if (req1)    give(1);
      else if (req2)    give(2);
      return;
    end
    my_req    = (m_owner == 1) ? req1  : req2;
    my_last   = (m_owner == 1) ? last1 : last2;
    other_req = (m_owner == 1) ? req2  : req1;
    if (!my_req || my_last) begin
      if (other_req) give(3 - m_owner);
      else begin m_owner = 0; m_cnt = 0; m_len = 0; end
    end else if (TEN && m_cnt >= HM && other_req) begin
      give(3 - m_owner);
      m_to = 1'b1;
    end else begin
      m_len++;
      if (m_cnt < HM) m_cnt++;
    end
  endtask

  task automatic check_outputs();
    chk("gnt1", gnt1, m_owner == 1);
    chk("gnt2", gnt2, m_owner == 2);
    chk("s", s, m_owner == 2);
    chk("out_valid", out_valid, m_owner != 0);
    chk("timeout", timeout, m_to);
    chk("out", out, (m_owner == 2) ? in2 : in1);
    chk("mutex", gnt1 & gnt2, 1'b0);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic drive(input bit r1, input bit r2, input bit l1, input bit l2);
    req1 = r1; req2 = r2; last1 = l1; last2 = l2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    int obs, obs_prev, run1, switches;
    bit switched, to_at_switch, any_to;

    // Reset state.
    drive(1, 1, 0, 0);
    rst_n = 1'b0;
    cycle();
    cycle();
    chk("rst_gnt1", gnt1, 1'b0);
    chk("rst_s", s, 1'b0);
    chk("rst_timeout", timeout, 1'b0);
    rst_n = 1'b1;
    drive(0, 0, 0, 0);
    cycle();

    // Single request: grant after one cycle, release after last.
    in1 = 8'h11; in2 = 8'h22;
    drive(1, 0, 0, 0);
    cycle();
    chk("single_gnt1", gnt1, 1'b1);
    chk("single_out", out, 8'h11);
    cycle(); cycle(); cycle();
    drive(1, 0, 1, 0);
    cycle();
    chk("single_release", gnt1, 1'b0);
    drive(0, 0, 0, 0);
    cycle();

    // Simultaneous requests after reset: 1 first, then 2 with no bubble.
    do_reset();
    in1 = 8'hA5; in2 = 8'h3C;
    drive(1, 1, 0, 0);
    cycle();
    chk("both_first", gnt1, 1'b1);
    drive(1, 1, 1, 0);
    cycle();
    chk("both_second_gnt2", gnt2, 1'b1);
    chk("both_second_s", s, 1'b1);
    chk("both_second_out", out, 8'h3C);
    drive(0, 0, 0, 0);
    cycle();

    // Fairness: last after every third grant cycle, grants must alternate.
    do_reset();
    drive(1, 1, 0, 0);
    obs_prev = 0;
    switches = 0;
    for (int k = 0; k < 36; k++) begin
      last1 = (m_owner == 1 && m_len == 3);
      last2 = (m_owner == 2 && m_len == 3);
      in1 = W'($urandom); in2 = W'($urandom);
      cycle();
      obs = gnt1 ? 1 : (gnt2 ? 2 : 0);
      if (obs != obs_prev && obs_prev != 0) begin
        chk("fair_alternate", obs, 3 - obs_prev);
        switches++;
      end
      obs_prev = obs;
    end
    chk("fair_switch_count", switches, 11);
    drive(0, 0, 0, 0);
    cycle();

    // Reset while requester 2 holds the grant.
    do_reset();
    drive(0, 1, 0, 0);
    cycle();
    chk("rst2_pre", gnt2, 1'b1);
    drive(1, 1, 0, 0);
    do_reset();
    chk("rst2_drop", gnt2, 1'b0);
    chk("rst2_s", s, 1'b0);
    cycle();
    chk("rst2_regrant", gnt1, 1'b1);

    // Reset while requester 1 holds the grant (favourite points at 2).
    drive(1, 1, 0, 0);
    do_reset();
    cycle();
    chk("rst1_regrant", gnt1, 1'b1);
    drive(0, 0, 0, 0);
    cycle();

    // Long hold: requester 1 never signals last while 2 waits.
    do_reset();
    drive(1, 1, 0, 0);
    run1 = 0; switched = 1'b0; to_at_switch = 1'b0; any_to = 1'b0;
    for (int k = 0; k < 60; k++) begin
      cycle();
      if (timeout) any_to = 1'b1;
      if (!switched) begin
        if (gnt1) run1++;
        else if (gnt2) begin
          switched = 1'b1;
          to_at_switch = timeout;
        end
      end
    end
`ifdef MUX2_ARB_TIMEOUT_EN
    chk("hold_len", run1, HM);
    chk("hold_timeout_pulse", to_at_switch, 1'b1);
`else
    chk("hold_len", run1, 60);
    chk("hold_no_timeout", any_to, 1'b0);
`endif
    drive(0, 0, 0, 0);
    cycle();

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 600; k++) begin
      req1  = ($urandom_range(0, 3) != 0);
      req2  = ($urandom_range(0, 3) != 0);
      last1 = ($urandom_range(0, 3) == 0);
      last2 = ($urandom_range(0, 3) == 0);
      rst_n = ($urandom_range(0, 49) != 0);
      in1   = W'($urandom);
      in2   = W'($urandom);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
